// File: rtl/nes_pad_responder_pkg.sv
// Shared constants for the NES pad responder: FSM state encoding and button bit order.
// Bit order matches the console-side controller reader (bit0 A ... bit7 Right).
// Optional turbo build (NES_PAD_TURBO_EN) uses the turbo_filter helper below.
package nes_pad_responder_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Button bit positions in the parallel vector and in the shift register
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // Bit counter value reached after the 7th shift; the next pulse ends the read
  localparam logic [2:0] LAST_BIT = 3'd7;

  // Forces masked buttons to "released" while the turbo phase is high
  function automatic logic [7:0] turbo_filter(input logic [7:0] btn,
                                              input logic [7:0] mask,
                                              input logic       phase);
    return phase ? (btn & ~mask) : btn;
  endfunction

endpackage

// File: rtl/nes_sync_edge.sv
// Synchronizes one asynchronous strobe into clk and flags its rising/falling edges.
// Latency: SYNC_STAGES clk to lvl; rise/fall are combinational off the last stage.
// No backpressure: free-running, edges are single-cycle.
module nes_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Next values: shift the raw input through the chain, keep one older copy for edge detect
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchronizer chain and edge-reference flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign lvl  = sync_q[SYNC_STAGES-1];
  assign rise = lvl & ~prev_q;
  assign fall = ~lvl & prev_q;

endmodule

// File: rtl/nes_pad_responder.sv
// Device-side NES pad: answers console latch/pulse strobes with the active-low 4021-style bit stream.
// Latency: SYNC_STAGES+1 clk from a latch/pulse edge to its effect on data/polled.
// No backpressure; optional turbo toggling of TURBO_MASK buttons under macro NES_PAD_TURBO_EN.
module nes_pad_responder #(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] TURBO_MASK   = 8'h03,
  parameter int         TURBO_PERIOD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       latch,
  input  logic       pulse,
  input  logic [7:0] buttons,
  output logic       data,
  output logic       polled,
  output logic       busy
);

  import nes_pad_responder_pkg::*;

  logic       latch_lvl, latch_rise, latch_fall;
  logic       pulse_lvl, pulse_rise, pulse_fall;
  logic [1:0] state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] cap_btn;

  nes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clk  (clk),
    .rst  (reset),
    .din  (latch),
    .lvl  (latch_lvl),
    .rise (latch_rise),
    .fall (latch_fall)
  );

  nes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pulse_sync (
    .clk  (clk),
    .rst  (reset),
    .din  (pulse),
    .lvl  (pulse_lvl),
    .rise (pulse_rise),
    .fall (pulse_fall)
  );

`ifdef NES_PAD_TURBO_EN
  localparam int PW = (TURBO_PERIOD > 1) ? $clog2(TURBO_PERIOD) : 1;

  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic          phase_q, phase_d;

  // Turbo phase flips after every TURBO_PERIOD completed polls
  always_comb begin
    poll_cnt_d = poll_cnt_q;
    phase_d    = phase_q;
    if (polled) begin
      if (poll_cnt_q == PW'(TURBO_PERIOD - 1)) begin
        poll_cnt_d = '0;
        phase_d    = ~phase_q;
      end else begin
        poll_cnt_d = poll_cnt_q + PW'(1);
      end
    end
  end

  // Turbo poll counter and phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      poll_cnt_q <= '0;
      phase_q    <= 1'b0;
    end else begin
      poll_cnt_q <= poll_cnt_d;
      phase_q    <= phase_d;
    end
  end

  assign cap_btn = turbo_filter(buttons, TURBO_MASK, phase_q);
`else
  logic unused_turbo_cfg;
  assign unused_turbo_cfg = ^{TURBO_MASK, TURBO_PERIOD[7:0]};
  assign cap_btn          = buttons;
`endif

  // Edge levels not needed beyond the detectors above
  logic unused_edges;
  assign unused_edges = latch_rise ^ pulse_lvl ^ pulse_fall;

  // Next-state logic: latch level wins over everything, including a same-cycle pulse edge
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    polled  = 1'b0;
    if (latch_lvl) begin
      state_d = ST_LOAD;
      sr_d    = cap_btn;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          // Final transparent capture happens in the same cycle the fall is seen
          sr_d    = cap_btn;
          cnt_d   = 3'd0;
          state_d = ST_SHIFT;
          polled  = latch_fall;
        end
        ST_SHIFT: begin
          if (pulse_rise) begin
            sr_d = {1'b0, sr_q[7:1]};
            if (cnt_q == LAST_BIT) begin
              state_d = ST_DONE;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // FSM, shift register and bit counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sr_q    <= 8'h00;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Serial output: idle high, pressed reads low, and a finished read reads "pressed"
  always_comb begin
    data = 1'b1;
    case (state_q)
      ST_LOAD, ST_SHIFT: data = ~sr_q[BTN_A];
      ST_DONE:           data = 1'b0;
      default:           data = 1'b1;
    endcase
  end

  assign busy = (state_q == ST_LOAD) || (state_q == ST_SHIFT);

endmodule

// File: tb/tb_nes_pad_responder.sv
// Randomized bench for nes_pad_responder with a queue-based scoreboard.
// Driver updates a bit-level pad model and pushes expectations; a negedge monitor pops and compares.
// Turbo expectations are applied when NES_PAD_TURBO_EN is defined.
module tb_nes_pad_responder;

  localparam logic [7:0] T_MASK   = 8'h03;
  localparam int         T_PERIOD = 2;

  logic       clk = 1'b0;
  logic       reset, latch, pulse;
  logic [7:0] buttons;
  logic       data, polled, busy;

  always #5 clk = ~clk;

  nes_pad_responder #(
    .SYNC_STAGES  (2),
    .TURBO_MASK   (T_MASK),
    .TURBO_PERIOD (T_PERIOD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .latch   (latch),
    .pulse   (pulse),
    .buttons (buttons),
    .data    (data),
    .polled  (polled),
    .busy    (busy)
  );

  typedef struct {
    string name;
    logic  data;
    logic  busy;
    int    polls;
  } exp_t;

  exp_t exp_q[$];
  logic chk_vld = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   poll_seen = 0;

  // Pad model: captured byte, number of bits already clocked out, poll counts
  logic [7:0] m_cap = 8'h00;
  int         m_idx = 0;
  bit         m_active = 0;
  int         m_polls = 0;
  int         m_tpolls = 0;

  function automatic logic [7:0] model_capture(input logic [7:0] b);
`ifdef NES_PAD_TURBO_EN
    if (((m_tpolls / T_PERIOD) % 2) == 1) return b & ~T_MASK;
`endif
    return b;
  endfunction

  // Monitor: counts poll strobes and checks the DUT whenever a check is presented
  always @(negedge clk) begin
    exp_t e;
    if (polled === 1'b1) poll_seen++;
    if (chk_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: got empty queue, required an entry");
      end else begin
        e = exp_q.pop_front();
        checks += 3;
        if (data !== e.data) begin
          errors++;
          $display("FAIL %s data: got %b required %b", e.name, data, e.data);
        end
        if (busy !== e.busy) begin
          errors++;
          $display("FAIL %s busy: got %b required %b", e.name, busy, e.busy);
        end
        if (poll_seen != e.polls) begin
          errors++;
          $display("FAIL %s polls: got %0d required %0d", e.name, poll_seen, e.polls);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string name);
    exp_t e;
    e.name  = name;
    e.polls = m_polls;
    if (!m_active) begin
      e.data = 1'b1;
      e.busy = 1'b0;
    end else if (m_idx >= 8) begin
      e.data = 1'b0;
      e.busy = 1'b0;
    end else begin
      e.data = ~m_cap[m_idx];
      e.busy = 1'b1;
    end
    exp_q.push_back(e);
    chk_vld = 1'b1;
    step(1);
    chk_vld = 1'b0;
  endtask

  task automatic latch_hi(input logic [7:0] b);
    buttons  = b;
    latch    = 1'b1;
    m_active = 1;
    m_idx    = 0;
    m_cap    = model_capture(b);
    step(5);
  endtask

  task automatic change_btn(input logic [7:0] b);
    buttons = b;
    m_cap   = model_capture(b);
    step(4);
  endtask

  task automatic latch_lo();
    latch = 1'b0;
    step(6);
    m_polls++;
    m_tpolls++;
  endtask

  task automatic pulse_once();
    pulse = 1'b1;
    step(4);
    pulse = 1'b0;
    step(4);
    if (m_active && m_idx < 8) m_idx++;
  endtask

  task automatic read_bits(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      pulse_once();
      expect_now(tag);
    end
  endtask

  task automatic full_poll(input logic [7:0] b, input int npulses, input string tag);
    latch_hi(b);
    latch_lo();
    expect_now(tag);
    read_bits(npulses, tag);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    m_active = 0;
    m_tpolls = 0;
    expect_now("reset_async");
    step(2);
    reset = 1'b0;
    step(2);
  endtask

  initial begin
    reset   = 1'b1;
    latch   = 1'b0;
    pulse   = 1'b0;
    buttons = 8'h00;
    step(3);
    expect_now("reset_state");
    reset = 1'b0;
    step(3);
    expect_now("idle");

    // Pulses in IDLE are ignored
    pulse_once();
    expect_now("idle_pulse");

    // Directed read of 8'b1000_0101 with a 12-clk latch, then 3 extra pulses
    latch_hi(8'b1000_0101);
    step(7);
    latch_lo();
    expect_now("read85_bit0");
    read_bits(8, "read85");
    read_bits(3, "done_extra");

    // Asynchronous reset in the middle of a read, then a clean all-pressed read
    latch_hi(8'hFF);
    latch_lo();
    read_bits(3, "ff_pre_reset");
    do_reset();
    expect_now("after_reset");
    full_poll(8'hFF, 8, "ff_read");

    // Latch and pulse rising together in SHIFT: reload wins, no shift
    full_poll(8'hA6, 3, "prio_pre");
    buttons  = 8'h5B;
    latch    = 1'b1;
    pulse    = 1'b1;
    m_active = 1;
    m_idx    = 0;
    m_cap    = model_capture(8'h5B);
    step(4);
    pulse = 1'b0;
    step(4);
    expect_now("prio_reload");
    latch_lo();
    expect_now("prio_bit0");
    read_bits(8, "prio_read");

    // Buttons change while latch high: the value at the falling edge is what gets read
    latch_hi(8'h01);
    change_btn(8'h02);
    latch_lo();
    expect_now("late_btn_bit0");
    read_bits(1, "late_btn_bit1");

    // Turbo cadence: six polls of A+B from a fresh reset
    do_reset();
    for (int p = 0; p < 6; p++) full_poll(8'h03, 2, "turbo");

    // Randomized polls: random buttons, latch length, mid-latch changes, pulse counts
    for (int it = 0; it < 24; it++) begin
      latch_hi(8'($urandom));
      step($urandom_range(0, 8));
      if ($urandom_range(0, 2) == 0) change_btn(8'($urandom));
      latch_lo();
      expect_now("rand_bit0");
      for (int k = 0, n = $urandom_range(0, 11); k < n; k++) begin
        pulse_once();
        buttons = 8'($urandom);
        expect_now("rand_bit");
      end
    end

    step(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
